mult_sequencer: RTL

Control FSM for the sequential shift-and-add multiplier datapath. Accepts a start request and emits one-cycle load, add and shift strobes that step the datapath through WORD_LENGTH iterations. The datapath returns the current multiplier LSB. The block raises a one-cycle done pulse when the product is complete. It sits between the top-level request logic and the multiplier datapath registers, and holds no operand data itself.

---
 rtl/mult_sequencer.sv | 87 ++++++++
 1 files changed

// File: rtl/mult_sequencer.sv
// Control sequencer for a shift-and-add multiplier datapath.
// Steps the datapath through WORD_LENGTH test/add/shift iterations after a
// start request and signals completion with a one-cycle done pulse.
module mult_sequencer #(
  parameter  int unsigned WORD_LENGTH = 5,
  localparam int unsigned CNT_WIDTH   = $clog2(WORD_LENGTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 multiplier_lsb,
  output logic                 load_operands,
  output logic                 add_en,
  output logic                 shift_en,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] iter_count
);

  localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(WORD_LENGTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_TEST  = 3'd2,
    S_ADD   = 3'd3,
    S_SHIFT = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic                 load_d;
  logic                 add_d;
  logic                 shift_d;
  logic                 busy_d;
  logic                 done_d;

  // Next-state, counter update and strobe decode of the upcoming state.
  always_comb begin
    state_d = state_q;
    cnt_d   = iter_count;
    case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_TEST;
      end
      S_TEST:  state_d = multiplier_lsb ? S_ADD : S_SHIFT;
      S_ADD:   state_d = S_SHIFT;
      S_SHIFT: begin
        cnt_d   = iter_count + CNT_WIDTH'(1);
        state_d = (iter_count == LAST_ITER) ? S_DONE : S_TEST;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    load_d  = (state_d == S_LOAD);
    add_d   = (state_d == S_ADD);
    shift_d = (state_d == S_SHIFT);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  // State, counter and registered strobes; outputs mirror the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      iter_count    <= '0;
      load_operands <= 1'b0;
      add_en        <= 1'b0;
      shift_en      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state_q       <= state_d;
      iter_count    <= cnt_d;
      load_operands <= load_d;
      add_en        <= add_d;
      shift_en      <= shift_d;
      busy          <= busy_d;
      done          <= done_d;
    end
  end

endmodule
